// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
package pipes;

    typedef enum logic {
        RUN,
        DISCARD
    } ctrl_state_t;

    typedef struct packed {
        logic pcEn;
        logic ifidEn;
        logic ifidClr;
        logic idexEn;
        logic idexClr;
        logic exmemEn;
        logic exmemClr;
        logic memwbEn;
        logic memwbClr;
    } pipe_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_mdu_occ_cnt.sv
// Counts cycles a mul/div has occupied EX; requests a stall until its last cycle.
module mdu_occ_cnt #(
    parameter int MDU_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic hold,
    input  logic clear,
    output logic stall
);

    localparam int CNT_W = $clog2(MDU_CYCLES + 1);

    logic [CNT_W-1:0] k;

    assign stall = start && (k < CNT_W'(MDU_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            k <= '0;
        end else if (!hold) begin
            if (stall) begin
                k <= k + CNT_W'(1);
            end else if (clear) begin
                k <= '0;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller: per-stage enable/clear, redirects, and
// discard of a fetch in flight that belongs to a squashed path.
module pipe_ctrl
    import pipes::*;
#(
    parameter int ADDR_W     = 64,
    parameter int MDU_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_busy,
    input  logic              d_busy,
    input  logic              load_use,
    input  logic              mdu_start,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              pc_en,
    output logic              redirect,
    output logic [ADDR_W-1:0] pc_target,
    output logic              ifid_en,
    output logic              ifid_clr,
    output logic              idex_en,
    output logic              idex_clr,
    output logic              exmem_en,
    output logic              exmem_clr,
    output logic              memwb_en,
    output logic              memwb_clr,
    output logic [31:0]       stall_cnt
);

    ctrl_state_t       state, nextState;
    logic [ADDR_W-1:0] pendTgt, nextPendTgt;
    logic [31:0]       stallCnt;
    pipe_ctrl_t        c;
    logic              redirectC;
    logic [ADDR_W-1:0] tgtC;
    logic              mduStall;

    mdu_occ_cnt #(
        .MDU_CYCLES(MDU_CYCLES)
    ) uOcc (
        .clk  (clk),
        .rst  (rst),
        .start(mdu_start),
        .hold (d_busy),
        .clear(c.exmemEn),
        .stall(mduStall)
    );

    always_comb begin
        c           = '0;
        redirectC   = 1'b0;
        tgtC        = '0;
        nextState   = state;
        nextPendTgt = pendTgt;
        // d_busy (and reset) leave every control at 0 and the state untouched
        if (rst && !d_busy) begin
            unique case (state)
                RUN: begin
                    if (mduStall) begin
                        c.exmemEn  = 1'b1;
                        c.exmemClr = 1'b1;
                        c.memwbEn  = 1'b1;
                    end else if (br_taken) begin
                        c.ifidEn  = 1'b1;
                        c.ifidClr = 1'b1;
                        c.idexEn  = 1'b1;
                        c.idexClr = 1'b1;
                        c.exmemEn = 1'b1;
                        c.memwbEn = 1'b1;
                        tgtC      = br_target;
                        if (!i_busy) begin
                            c.pcEn    = 1'b1;
                            redirectC = 1'b1;
                        end else begin
                            nextPendTgt = br_target;
                            nextState   = DISCARD;
                        end
                    end else if (load_use) begin
                        c.idexEn  = 1'b1;
                        c.idexClr = 1'b1;
                        c.exmemEn = 1'b1;
                        c.memwbEn = 1'b1;
                    end else if (i_busy) begin
                        c.ifidEn  = 1'b1;
                        c.ifidClr = 1'b1;
                        c.idexEn  = 1'b1;
                        c.exmemEn = 1'b1;
                        c.memwbEn = 1'b1;
                    end else begin
                        c.pcEn    = 1'b1;
                        c.ifidEn  = 1'b1;
                        c.idexEn  = 1'b1;
                        c.exmemEn = 1'b1;
                        c.memwbEn = 1'b1;
                    end
                end
                DISCARD: begin
                    // IF/ID always flushed here; back end runs as in RUN minus branches
                    c.ifidEn  = 1'b1;
                    c.ifidClr = 1'b1;
                    tgtC      = pendTgt;
                    if (mduStall) begin
                        c.exmemEn  = 1'b1;
                        c.exmemClr = 1'b1;
                        c.memwbEn  = 1'b1;
                    end else begin
                        c.idexEn  = 1'b1;
                        c.idexClr = load_use;
                        c.exmemEn = 1'b1;
                        c.memwbEn = 1'b1;
                    end
                    if (!i_busy) begin
                        c.pcEn    = 1'b1;
                        redirectC = 1'b1;
                        nextState = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            pendTgt  <= '0;
            stallCnt <= '0;
        end else begin
            state   <= nextState;
            pendTgt <= nextPendTgt;
            if (!c.pcEn && stallCnt != '1) begin
                stallCnt <= stallCnt + 32'd1;
            end
        end
    end

    assign pc_en     = c.pcEn;
    assign redirect  = redirectC;
    assign pc_target = tgtC;
    assign ifid_en   = c.ifidEn;
    assign ifid_clr  = c.ifidClr;
    assign idex_en   = c.idexEn;
    assign idex_clr  = c.idexClr;
    assign exmem_en  = c.exmemEn;
    assign exmem_clr = c.exmemClr;
    assign memwb_en  = c.memwbEn;
    assign memwb_clr = c.memwbClr;
    assign stall_cnt = stallCnt;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and sequencing controller for the five-stage AArch64 pipeline. It produces the per-stage enable/clear controls for the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves memory-wait stalls, multi-cycle MDU occupancy, load-use bubbles, taken-branch redirects and fetch-in-flight redirect discard. It sits beside the datapath in the core top and owns no datapath state except a pending redirect target and a stall counter.

## Interface
- `ADDR_W`, 64, PC/target width
- `MDU_CYCLES`, 4, cycles a mul/div occupies EX (≥1; 1 = no stall)
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-low reset
- `i_busy`  in  1  fetch request outstanding, no instruction this cycle
- `d_busy`  in  1  MEM-stage access not yet complete
- `load_use`  in  1  ID source matches load destination in EX
- `mdu_start`  in  1  instruction in EX is a mul/div
- `br_taken`  in  1  EX resolved a redirect
- `br_target`  in  ADDR_W  redirect target
- `pc_en`, `redirect`  out  1  PC load enable; select `pc_target`
- `pc_target`  out  ADDR_W  next PC when `redirect`=1
- `ifid_en`, `ifid_clr`, `idex_en`, `idex_clr`, `exmem_en`, `exmem_clr`, `memwb_en`, `memwb_clr`  out  1 each  pipe-register controls; a clear takes effect only with its enable
- `stall_cnt`  out  32  saturating count of cycles with `pc_en`=0

## Operation
- States: RUN, DISCARD. Registers: state, MDU occupancy count `k`, `pend_tgt`, `stall_cnt`.
- RUN uses the first matching rule per cycle:
  1. `d_busy`: every enable is 0, every clear is 0, `k` is frozen, and `br_taken` is ignored. EX is held, so the branch re-presents.
  2. MDU stall (`mdu_start` && `k` < MDU_CYCLES-1): `pc_en`, `ifid_en` and `idex_en` are 0. EX/MEM and MEM/WB are enabled, with `exmem_clr`=1 to insert a bubble. `k` increments.
  3. `br_taken`: IF/ID and ID/EX are enabled and cleared. EX/MEM and MEM/WB advance. `pc_target`=`br_target`.
     - If `i_busy`=0: `pc_en`=1 and `redirect`=1.
     - If `i_busy`=1: `pc_en`=0, `pend_tgt` is set to `br_target`, and the state moves to DISCARD.
  4. `load_use`: `pc_en` and `ifid_en` are 0. ID/EX is enabled and cleared. EX/MEM and MEM/WB advance.
  5. `i_busy`: `pc_en`=0. IF/ID is enabled and cleared. The rest advance.
  6. Otherwise: all enables are 1 and all clears are 0.
- `k` returns to 0 on any cycle where EX advances (`exmem_en`=1 and rule 2 not active).
- DISCARD (the fetch in flight belongs to the squashed path):
  - While `i_busy`=1: `pc_en`=0 and IF/ID is enabled and cleared. The back end follows rules 1, 2, 4 and 6 with IF/ID forced clear.
  - First cycle with `i_busy`=0: the returning instruction is dropped (`ifid_clr`=1), `pc_en`=1, `redirect`=1, `pc_target`=`pend_tgt`, and the state returns to RUN.
  - If `d_busy` is also set that cycle, the PC load waits. DISCARD is held until a cycle with `d_busy`=0.
- `br_taken` cannot be asserted in DISCARD, because ID/EX was cleared. If it is asserted there anyway, it is ignored.
- `stall_cnt` increments on every post-reset cycle with `pc_en`=0 and saturates at 0xFFFF_FFFF.

## Timing
- All controls are combinational from the inputs and state, and are valid in the same cycle. The pipe registers sample them on the next `posedge clk`.
- Values while `rst`=0 are sampled at the edge:
  - next state is RUN, with `k`=0, `pend_tgt`=0 and `stall_cnt`=0;
  - all enables, clears, `redirect` and `pc_target` drive 0.
- Reset in DISCARD drops the pending redirect.
- MDU instruction: EX holds it for exactly MDU_CYCLES non-`d_busy` cycles, with MDU_CYCLES-1 bubbles into EX/MEM.
- Redirect with no fetch in flight costs 0 extra cycles (PC loads in the same cycle). With a fetch in flight it costs the remaining `i_busy` cycles plus one.
- `d_busy` overrides everything and causes no state change, except `stall_cnt`.

## Structure
- Add a `pipe_ctrl_t` struct to package `pipes` with en/clr per stage. The outputs may be bundled as one `pipe_ctrl_t`.
- Add a `ctrl_state_t` enum (RUN, DISCARD) to package `pipes`.
- Sub-module `mdu_occ_cnt`: the `k` counter, width $clog2(MDU_CYCLES+1), with inputs `hold` and `clear` and output `stall`.

## Test plan
- Idle, all inputs 0 after reset → all en=1, clr=0, `stall_cnt`=0. During reset → all controls 0.
- MDU_CYCLES=4, `mdu_start` held 4 cycles → `pc_en`=0 for 3 cycles with `exmem_clr`=1, then advance. With `d_busy` pulsed in cycle 2, the stall extends by 1 and `k` is frozen.
- `load_use` + `br_taken` in the same cycle, `br_target`=0x4000 → redirect wins: `pc_target`=0x4000, `ifid_clr`=`idex_clr`=1, `pc_en`=1.
- `br_taken` with `br_target`=0x8000 while `i_busy`=1 for 3 more cycles → DISCARD: `ifid_clr`=1 each cycle. The cycle `i_busy` falls gives `redirect`=1 and `pc_target`=0x8000, and the state returns to RUN.
- `d_busy` and `br_taken` both held 5 cycles, then `d_busy`=0 → 5 cycles of all-hold, then the redirect fires. `stall_cnt` reads 5.
- Reset asserted while in DISCARD → RUN, with no redirect after reset.
